// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - time-multiplexed FIR filter built around one signed multiply-accumulate unit
// Optional output saturation is enabled by defining FIR_MAC_SAT_EN.
module fir_mac #(
  parameter int WIDTH       = 10,
  parameter int TAPS        = 32,
  parameter int COEFF_WIDTH = 17,
  parameter int SHIFT       = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      coeff_we,
  input  logic [$clog2(TAPS)-1:0]   coeff_addr,
  input  logic [COEFF_WIDTH-1:0]    coeff_data
);
  localparam int PW     = $clog2(TAPS);
  localparam int PROD_W = WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + PW;
  localparam logic [PW:0]   TAPS_W = (PW+1)'(TAPS);
  localparam logic [PW-1:0] LAST   = PW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                        state;
  logic signed [WIDTH-1:0]       x [TAPS];
  logic signed [COEFF_WIDTH-1:0] c [TAPS];
  logic [PW-1:0]                 wptr;
  logic [PW-1:0]                 newest;
  logic [PW-1:0]                 k;
  logic [PW-1:0]                 rd_idx;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       acc_next;

  // newest-k modulo TAPS; the extra bit keeps this correct for non-power-of-two TAPS
  assign rd_idx   = (newest >= k) ? (newest - k)
                                  : PW'({1'b0, newest} + TAPS_W - {1'b0, k});
  assign prod     = PROD_W'(x[rd_idx]) * PROD_W'(c[k]);
  assign acc_next = acc + ACC_W'(prod);

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  function automatic logic [WIDTH-1:0] shape_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_MAX)      return WIDTH'(SAT_MAX);
    else if (s < SAT_MIN) return WIDTH'(SAT_MIN);
    else                  return s[WIDTH-1:0];
  endfunction
`else
  function automatic logic [WIDTH-1:0] shape_out(input logic signed [ACC_W-1:0] a);
    return WIDTH'(a >>> SHIFT);
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      wptr      <= '0;
      newest    <= '0;
      k         <= '0;
      acc       <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write in the accept cycle lands before the first MAC product reads c[].
          if (coeff_we && ({1'b0, coeff_addr} < TAPS_W))
            c[coeff_addr] <= $signed(coeff_data);
          if (in_valid) begin
            x[wptr]  <= $signed(in_data);
            newest   <= wptr;
            wptr     <= (wptr == LAST) ? '0 : wptr + PW'(1);
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == LAST) begin
            out_data  <= shape_out(acc_next);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + PW'(1);
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac.sv
// tb/tb_fir_mac.sv - self-checking bench for fir_mac (TAPS=4, WIDTH=10, COEFF_WIDTH=17, SHIFT=0)
// Honours FIR_MAC_SAT_EN for the expected overflow behaviour.
module tb_fir_mac;
  localparam int WIDTH = 10;
  localparam int TAPS  = 4;
  localparam int CW    = 17;
  localparam int SHIFT = 0;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data = '0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    coeff_we = 1'b0;
  logic [1:0]              coeff_addr = '0;
  logic [CW-1:0]           coeff_data = '0;

  fir_mac #(.WIDTH(WIDTH), .TAPS(TAPS), .COEFF_WIDTH(CW), .SHIFT(SHIFT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: coefficient list and sample history, mx[0] is the newest sample.
  int mc [TAPS];
  int mx [TAPS];

  typedef struct {
    int din;
    int dout;
  } vec_t;
  vec_t imp [6];

  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mc[i] = 0;
      mx[i] = 0;
    end
  endfunction

  function automatic void model_push(input int s);
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
  endfunction

  function automatic int model_out();
    longint acc;
    longint v;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(mc[i]) * longint'(mx[i]);
    acc = acc >>> SHIFT;
`ifdef FIR_MAC_SAT_EN
    if (acc > 511) v = 511;
    else if (acc < -512) v = -512;
    else v = acc;
`else
    v = acc & 64'd1023;
    if (v >= 512) v -= 1024;
`endif
    return int'(v);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_out(output int got);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    got = int'(out_data);
  endtask

  task automatic load_coeff(input int a, input int v);
    wait_ready();
    coeff_we   = 1'b1;
    coeff_addr = 2'(a);
    coeff_data = CW'(v);
    tick();
    coeff_we = 1'b0;
    mc[a] = v;
  endtask

  task automatic send_sample(input int s, output int got, output int exp);
    wait_ready();
    in_valid = 1'b1;
    in_data  = WIDTH'(s);
    tick();
    in_valid = 1'b0;
    model_push(s);
    exp = model_out();
    wait_out(got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got, exp, n, seen;
    model_reset();

    // Reset held three cycles with in_valid high
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 10'd77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || !in_ready) seen++;
    end
    check("rst_sample_not_accepted", seen, 0);

    // Impulse response and history wrap
    imp[0] = '{1, 1};
    imp[1] = '{0, 2};
    imp[2] = '{0, 3};
    imp[3] = '{0, -1};
    imp[4] = '{0, 0};
    imp[5] = '{5, 5};
    load_coeff(0, 1);
    load_coeff(1, 2);
    load_coeff(2, 3);
    load_coeff(3, -1);
    for (int i = 0; i < 6; i++) begin
      send_sample(imp[i].din, got, exp);
      check($sformatf("impulse[%0d]", i), got, imp[i].dout);
      check($sformatf("impulse_model[%0d]", i), got, exp);
    end

    // Latency and back-to-back handshake with in_valid held
    wait_ready();
    in_valid = 1'b1;
    in_data = WIDTH'(7);
    tick();
    model_push(7);
    exp = model_out();
    in_data = WIDTH'(-3);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("lat_in_ready_t%0d", i), in_ready, 0);
      check($sformatf("lat_out_valid_t%0d", i), out_valid, (i == 5) ? 1 : 0);
      if (i == 5) check("lat_out_data", out_data, exp);
      tick();
    end
    check("lat_in_ready_t6", in_ready, 1);
    tick();
    check("lat_accept_at_t6", in_ready, 0);
    in_valid = 1'b0;
    model_push(-3);
    exp = model_out();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("lat_second_delay", n, 4);
    check("lat_second_data", out_data, exp);

    // Overflow: wrap by default, clamp with saturation
    load_coeff(0, 100);
    load_coeff(1, 0);
    load_coeff(2, 0);
    load_coeff(3, 0);
    send_sample(100, got, exp);
`ifdef FIR_MAC_SAT_EN
    check("ovf_pos", got, 511);
`else
    check("ovf_pos", got, -240);
`endif
    send_sample(-100, got, exp);
`ifdef FIR_MAC_SAT_EN
    check("ovf_neg", got, -512);
`else
    check("ovf_neg", got, 240);
`endif

    // Coefficient writes during MAC and DONE are dropped
    load_coeff(0, 1);
    wait_ready();
    in_valid = 1'b1;
    in_data = WIDTH'(3);
    tick();
    in_valid = 1'b0;
    model_push(3);
    exp = model_out();
    coeff_we = 1'b1;
    coeff_addr = 2'd0;
    coeff_data = CW'(7);
    tick();
    coeff_we = 1'b0;
    wait_out(got);
    check("gate_mac_write", got, 3);
    check("gate_mac_model", got, exp);
    coeff_we = 1'b1;
    coeff_addr = 2'd1;
    coeff_data = CW'(50);
    tick();
    coeff_we = 1'b0;
    // Write coinciding with a sample accept in IDLE applies to that sample
    wait_ready();
    in_valid = 1'b1;
    in_data = WIDTH'(3);
    coeff_we = 1'b1;
    coeff_addr = 2'd0;
    coeff_data = CW'(7);
    tick();
    in_valid = 1'b0;
    coeff_we = 1'b0;
    mc[0] = 7;
    model_push(3);
    exp = model_out();
    wait_out(got);
    check("gate_idle_write", got, 21);
    check("gate_idle_model", got, exp);

    // Randomized coefficients and samples against the model
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < TAPS; a++)
        load_coeff(a, int'($urandom_range(0, 131071)) - 65536);
      for (int i = 0; i < 12; i++) begin
        send_sample(int'($urandom_range(0, 1023)) - 512, got, exp);
        check($sformatf("random[%0d][%0d]", r, i), got, exp);
      end
    end

    // Reset during MAC: result dropped, history and coefficients cleared
    load_coeff(0, 1);
    load_coeff(1, 2);
    load_coeff(2, 3);
    load_coeff(3, -1);
    send_sample(40, got, exp);
    send_sample(-30, got, exp);
    wait_ready();
    in_valid = 1'b1;
    in_data = WIDTH'(4);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst_no_valid", seen, 0);
    send_sample(9, got, exp);
    check("midrst_coeff_zero", got, 0);
    load_coeff(0, 1);
    load_coeff(1, 2);
    load_coeff(2, 3);
    load_coeff(3, -1);
    send_sample(1, got, exp);
    check("midrst_hist_cleared", got, 19);
    for (int i = 0; i < 4; i++) begin
      send_sample(0, got, exp);
      check($sformatf("midrst_tail[%0d]", i), got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      send_sample((i == 0) ? 1 : 0, got, exp);
      check($sformatf("midrst_impulse[%0d]", i), got, imp[i].dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_mac.md
# fir_mac

Time-multiplexed, parametrised FIR filter built around one signed multiply-accumulate unit.
- Accepts one sample per valid/ready handshake and computes the full TAPS-length convolution over TAPS clock cycles.
- Emits one registered result per input sample.
- Coefficients are runtime-loadable through a write port.
- Sits in the sample datapath between converter front-end and downstream processing wherever sample rate is at most clock/(TAPS+2).
- Trades throughput for area against a fully parallel filter.

## Interface
- WIDTH, 10, sample width (signed two's complement, in and out)
- TAPS, 32, filter length; must be ≥2
- COEFF_WIDTH, 17, coefficient width (signed two's complement)
- SHIFT, 15, arithmetic right shift applied to accumulator before output
- clock  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  sample available
- in_ready  output  1  block can accept a sample
- in_data  input  WIDTH  input sample
- out_valid  output  1  one-cycle pulse, out_data valid
- out_data  output  WIDTH  filtered sample
- coeff_we  input  1  coefficient write strobe
- coeff_addr  input  $clog2(TAPS)  tap index to write
- coeff_data  input  COEFF_WIDTH  coefficient value

## Operation
- Storage: history register file x[0..TAPS-1] as circular buffer with write pointer; coefficient register file c[0..TAPS-1].
- Definition: y[n] = (Σ k=0..TAPS-1 c[k]·x[n-k]) >>> SHIFT; newest sample pairs with c[0].
- Samples before reset count as zero.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: write in_data at write pointer, advance pointer with wrap at TAPS-1→0, clear accumulator, k=0, go to MAC.
  - MAC: one product per cycle, acc += c[k]·x[ptr_newest-k mod TAPS]. Advance k. After the product for k=TAPS-1, go to DONE.
  - DONE: drive out_data from final accumulator, out_valid=1 for this cycle only, return to IDLE.
- Arithmetic:
  - Product is WIDTH+COEFF_WIDTH bits, signed.
  - Accumulator ACC_W = WIDTH+COEFF_WIDTH+$clog2(TAPS) bits, sign-extended; the accumulator never overflows.
  - Output = (acc >>> SHIFT) reduced to WIDTH bits per Configuration.
- Coefficient writes: honoured only in IDLE, taking effect the next cycle. coeff_we in MAC/DONE is ignored (dropped, not queued). A write coinciding with a sample accept in IDLE applies before that sample's MAC.
- No output backpressure: out_valid is a pulse and the consumer must take it.
- in_valid held while in_ready=0 is not consumed. The sample is accepted when IDLE is re-entered.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0.
  - All x[] and c[] are 0, write pointer 0, k 0, accumulator 0.
- Sample accepted at edge t → MAC cycles t+1..t+TAPS → out_valid high on cycle t+TAPS+1 → IDLE, in_ready=1 at t+TAPS+2.
- Maximum throughput: one sample per TAPS+2 cycles.
- out_data holds its value between pulses.
- Reset mid-operation (any state): next cycle in IDLE with all reset values. The in-flight result is never emitted and history is cleared.
- reset has priority over every other input in the same cycle.

## Configuration
- FIR_MAC_SAT_EN defined: (acc >>> SHIFT) is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before output.
- FIR_MAC_SAT_EN undefined: low WIDTH bits are taken (two's-complement wrap). No saturation logic is instantiated.

## Test plan
All scenarios use TAPS=4, WIDTH=10, COEFF_WIDTH=17, SHIFT=0 unless stated.
- Reset: hold reset 3 cycles with in_valid=1 → in_ready=1, out_valid=0, out_data=0. The sample is not accepted during reset.
- Impulse response: load c={1,2,3,-1}, send 1,0,0,0,0 → outputs 1,2,3,-1,0. Then send 5 → output 5 (history wrapped correctly).
- Latency/handshake: accept at cycle t → in_ready=0 on t+1..t+5, out_valid only on t+5, in_ready=1 at t+6. Hold in_valid continuously → next accept exactly at t+6.
- Overflow: c={100,0,0,0}, input 100 → 784-1024=-240 without FIR_MAC_SAT_EN, 511 with it. Input -100 → 240 without, -512 with.
- Coefficient gating: write c[0]=7 during MAC → result unchanged. Same write in IDLE → next output scaled by 7.
- Reset mid-MAC: after building history, assert reset at t+2 → no out_valid. Subsequent impulse test reproduces 1,2,3,-1 with coefficients reloaded (c[] reset to 0 gives all-zero output before reload).
